// File: rtl/lsu_issue_bypass.sv
// Request queue feeding the load and store units: a small circular buffer with
// a zero-latency combinational bypass of the issue request while it is empty.

package lsu_issue_bypass_pkg;
    typedef struct packed {
        logic        valid;
        logic [3:0]  trans_id;
        logic        is_store;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_ctrl_t;
endpackage

module lsu_issue_bypass
    import lsu_issue_bypass_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      clr_i,
    input  logic      flush_i,
    input  lsu_ctrl_t lsu_req_i,
    input  logic      lsu_req_valid_i,
    input  logic      pop_ld_i,
    input  logic      pop_st_i,
    output lsu_ctrl_t lsu_ctrl_o,
    output logic      ready_o,
    output logic      empty_o
);

    lsu_ctrl_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic w_kill;
    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_wr_en;
    logic w_rd_en;
    logic w_push_drop;

    assign w_kill   = flush_i | clr_i;
    assign w_push   = lsu_req_valid_i & ~w_kill;
    assign w_pop    = (pop_ld_i | pop_st_i) & ~w_kill;
    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == CNT_W'(DEPTH));

    // A request consumed in its issue cycle never touches storage.
    assign w_bypass    = w_empty & w_push & w_pop;
    assign w_wr_en     = w_push & ~w_full & ~w_bypass;
    assign w_rd_en     = w_pop & ~w_empty;
    assign w_push_drop = w_push & w_full;

    always_comb begin
        if (w_empty) begin
            lsu_ctrl_o       = lsu_req_i;
            lsu_ctrl_o.valid = lsu_req_valid_i;
        end else begin
            lsu_ctrl_o       = r_mem[r_rd_ptr];
            lsu_ctrl_o.valid = 1'b1;
        end
        if (w_kill) begin
            lsu_ctrl_o.valid = 1'b0;
        end
    end

    // One slack entry absorbs a push made while issue still sees the old ready.
    assign ready_o = (r_cnt < CNT_W'(DEPTH - 1));
    assign empty_o = w_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else if (w_kill) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_cnt <= r_cnt + CNT_W'(w_wr_en) - CNT_W'(w_rd_en);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr] <= lsu_req_i;
        end
    end

    a_single_pop : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_ld_i && pop_st_i))
        else $error("lsu_issue_bypass: load and store pop asserted together");

    a_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_pop && w_empty && !w_push))
        else $error("lsu_issue_bypass: pop with nothing presented");

    // Overflow is an issue-side protocol slip; the push is dropped and reported.
    a_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !w_push_drop)
        else $warning("lsu_issue_bypass: push dropped, queue full");

endmodule

// File: doc/lsu_issue_bypass.md
Name: lsu_issue_bypass

Overview:
- Small request queue directly upstream of the store unit and load unit.
- Accepts one decoded LSU request per cycle from issue and presents exactly one request (lsu_ctrl_t) to both units.
- Entries retire when the load unit or store unit pops them.
- When empty, the incoming request bypasses storage combinationally so a unit can accept it in the issue cycle.

Parameters:
- DEPTH, 2, number of queued entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy counter (derived, not overridden).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous reset, active low
- clr_i  input  1  synchronous clear, active high
- flush_i  input  1  pipeline flush, discard all queued requests
- lsu_req_i  input  lsu_ctrl_t  request from issue; its valid field is ignored
- lsu_req_valid_i  input  1  push strobe for lsu_req_i
- pop_ld_i  input  1  load unit consumed the presented request
- pop_st_i  input  1  store unit consumed the presented request
- lsu_ctrl_o  output  lsu_ctrl_t  request presented to load/store units
- ready_o  output  1  issue may push this cycle
- empty_o  output  1  queue holds no entries

Behaviour:
- Storage: DEPTH-entry circular buffer with read pointer, write pointer (log2(DEPTH) bits, wrap naturally) and occupancy cnt_q (0..DEPTH).
- Reset (rst_ni low, async):
  - pointers = 0, cnt_q = 0, all entries = '0.
  - Outputs follow the empty case: ready_o = 1, empty_o = 1, lsu_ctrl_o = bypass of lsu_req_i.
- push = lsu_req_valid_i & ~flush_i & ~clr_i.
- pop = (pop_ld_i | pop_st_i) & ~flush_i & ~clr_i.
  - pop_ld_i and pop_st_i are never both high; an assertion flags it, and the pair counts as one pop.
- Output mux (combinational):
  - cnt_q == 0: lsu_ctrl_o = lsu_req_i with valid = lsu_req_valid_i (bypass, zero latency).
  - cnt_q > 0: lsu_ctrl_o = entry[rd_ptr] with valid = 1.
  - flush_i or clr_i high: lsu_ctrl_o.valid forced 0; other fields unchanged.
- Update rules:
  - Empty, push & pop: bypassed request consumed same cycle; nothing written; cnt unchanged (0).
  - Empty, push only: write entry[wr_ptr], wr_ptr++, cnt 0->1; the same request is presented next cycle from storage.
  - Non-empty, pop only: rd_ptr++, cnt--.
  - Non-empty, push & pop: write and read both advance; cnt unchanged; the new entry lands behind the head.
  - Pop while empty with no push: ignored (assertion flags it).
  - Push while cnt_q == DEPTH: dropped, state unchanged (assertion flags it). Issue must honour ready_o.
- ready_o = (cnt_q < DEPTH-1). Registered-state only; no combinational path from pop inputs. This leaves one slack entry for the cycle issue sees ready late.
- empty_o = (cnt_q == 0).
- flush_i / clr_i: next cycle rd_ptr = wr_ptr = 0 and cnt_q = 0. Pushes and pops in that cycle are discarded. Entry contents need not be cleared. clr_i has priority equal to flush_i.
- Reset mid-operation: immediate return to reset state regardless of pending push/pop.
- No request reordering; strict FIFO order between issue and units.

Test Plan:
- Reset, then push A (trans_id=3) with pop_st_i high in the same cycle:
  - lsu_ctrl_o = A, valid = 1, combinationally.
  - Next cycle: cnt = 0, empty_o = 1, ready_o = 1.
- Push A (trans_id=1), no pop:
  - Next cycle: lsu_ctrl_o = A from storage, valid = 1, ready_o = 0, empty_o = 0.
  - Pop_ld_i -> cnt 0 and ready_o = 1 one cycle later.
- Fill with A (id=1) and B (id=2) while holding pops low (B pushed despite ready_o = 0, using slack):
  - cnt = 2.
  - Push C -> dropped and assertion fires.
  - Pop twice -> outputs id 1 then id 2, then empty.
- Pointer wrap: 6 push/pop sequences alternating (push, pop) at cnt = 1 for DEPTH = 2:
  - Presented trans_id order 1..6 exactly, with no duplicates or losses across rd/wr pointer wrap.
- Queue holding 2 entries, assert flush_i with push D and pop_st_i in the same cycle:
  - During flush: lsu_ctrl_o.valid = 0.
  - Next cycle: cnt = 0, empty_o = 1, ready_o = 1, D never presented.
  - Repeat the sequence with clr_i: same result.
- Assert rst_ni low while cnt = 1 with a simultaneous push:
  - Immediately empty_o = 1 and ready_o = 1.
  - After release, the first push is presented with trans_id intact.
